// File: rtl/mac_seq_pkg.sv
// Shared types and sizing helpers for the sequential multiply-accumulate engine.
// Every instance derives its digit count and result width from its own parameters.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIGIT = 2;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int result_width(input int width);
    return 2 * width + 1;
  endfunction

  // The digit index counter needs at least one bit, even when a single digit spans all of Y.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_digit_pp.sv
// Combinational partial product of the multiplicand with one radix-2^DIGIT digit of Y.
module mac_digit_pp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic [WIDTH-1:0]       x,
  input  logic [DIGIT-1:0]       digit,
  output logic [WIDTH+DIGIT-1:0] pp
);

  assign pp = {{DIGIT{1'b0}}, x} * {{WIDTH{1'b0}}, digit};

endmodule

// File: rtl/mac_seq_engine.sv
// Sequential X*Y +/- Z engine: Y is consumed one digit per CALC cycle, then a single
// FINAL cycle applies Z and pulses done.
module mac_seq_engine
  import mac_seq_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DIGIT      = DEFAULT_DIGIT,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     x_val,
  input  logic [WIDTH-1:0]     y_val,
  input  logic [WIDTH-1:0]     z_val,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     result
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int RW    = result_width(WIDTH);
  localparam int IW    = index_width(N);
  localparam int ACC_W = 2 * WIDTH;
  localparam int PP_W  = WIDTH + DIGIT;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic             mode_q;
  logic [ACC_W-1:0] acc_q;
  logic [IW-1:0]    idx_q;
  logic [RW-1:0]    result_q;
  logic             done_q;

  logic [DIGIT-1:0] digit;
  logic [PP_W-1:0]  pp;
  logic [ACC_W-1:0] pp_shifted;
  logic [WIDTH-1:0] y_rest;
  logic             rest_zero;
  logic             last_digit;
  logic [RW-1:0]    acc_ext;
  logic [RW-1:0]    z_ext;
  logic [RW-1:0]    final_val;

  // y_q is shifted down each CALC cycle, so the current digit is always its low bits.
  assign digit     = y_q[DIGIT-1:0];
  assign y_rest    = y_q >> DIGIT;
  assign rest_zero = (y_rest == '0);

  mac_digit_pp #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit_pp (
    .x     (x_q),
    .digit (digit),
    .pp    (pp)
  );

  always_comb begin
    pp_shifted = ACC_W'(pp) << (int'(idx_q) * DIGIT);
    last_digit = (idx_q == IW'(N - 1)) || (EARLY_EXIT && rest_zero);
    acc_ext    = RW'(acc_q);
    z_ext      = RW'(z_q);
    final_val  = mode_q ? (acc_ext - z_ext) : (acc_ext + z_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_digit) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured only in IDLE, so later start pulses and input changes are inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mode_q   <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q    <= x_val;
            y_q    <= y_val;
            z_q    <= z_val;
            mode_q <= mode;
            acc_q  <= '0;
            idx_q  <= '0;
          end
        end
        CALC: begin
          acc_q <= acc_q + pp_shifted;
          y_q   <= y_rest;
          idx_q <= idx_q + IW'(1);
        end
        FINAL: begin
          result_q <= final_val;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FINAL);
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mac_seq_engine.sv
// Directed bench for mac_seq_engine: an early-exit and a fixed-latency instance are checked
// every cycle against a transaction-level model, plus hand-computed literal results.
module tb_mac_seq_engine;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int N  = W / D;
  localparam int RW = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    start = '0;
  logic          mode = 1'b0;
  logic [W-1:0]  x_val = '0;
  logic [W-1:0]  y_val = '0;
  logic [W-1:0]  z_val = '0;
  logic [1:0]    busy_w;
  logic [1:0]    done_w;
  logic [RW-1:0] res_w [2];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mac_seq_engine #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode),
    .x_val(x_val), .y_val(y_val), .z_val(z_val),
    .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0])
  );

  mac_seq_engine #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b0)) dut_fx (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode),
    .x_val(x_val), .y_val(y_val), .z_val(z_val),
    .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1])
  );

  // Number of CALC cycles from the position of Y's most significant set bit.
  function automatic int calc_cycles(input logic [W-1:0] y, input bit ee);
    int bits;
    if (!ee) return N;
    bits = 0;
    for (int b = 0; b < W; b++) if (y[b]) bits = b + 1;
    if (bits == 0) return 1;
    return (bits + D - 1) / D;
  endfunction

  function automatic logic [RW-1:0] expected_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                                    input logic [W-1:0] z, input bit m);
    longint p;
    p = longint'(x) * longint'(y);
    p = m ? (p - longint'(z)) : (p + longint'(z));
    return p[RW-1:0];
  endfunction

  logic          m_busy [2];
  logic          m_done [2];
  logic [RW-1:0] m_res  [2];
  logic [RW-1:0] m_pend [2];
  int            m_cnt  [2];

  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam bit EE = (g == 0);
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy[g] <= 1'b0;
        m_done[g] <= 1'b0;
        m_res[g]  <= '0;
        m_pend[g] <= '0;
        m_cnt[g]  <= 0;
      end else begin
        m_done[g] <= 1'b0;
        if (!m_busy[g]) begin
          if (start[g]) begin
            m_busy[g] <= 1'b1;
            m_cnt[g]  <= calc_cycles(y_val, EE) + 1;
            m_pend[g] <= expected_result(x_val, y_val, z_val, mode);
          end
        end else begin
          m_cnt[g] <= m_cnt[g] - 1;
          if (m_cnt[g] == 1) begin
            m_busy[g] <= 1'b0;
            m_done[g] <= 1'b1;
            m_res[g]  <= m_pend[g];
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("model_busy[%0d]", k), 32'(busy_w[k]), 32'(m_busy[k]));
        checkOutput($sformatf("model_done[%0d]", k), 32'(done_w[k]), 32'(m_done[k]));
        checkOutput($sformatf("model_result[%0d]", k), 32'(res_w[k]), 32'(m_res[k]));
      end
    end
  end

  // Returns just after the accepting edge; operands are then scrambled to prove capture.
  task automatic applyStimulus(input int k, input bit m, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] z);
    @(negedge clk);
    mode     = m;
    x_val    = x;
    y_val    = y;
    z_val    = z;
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    x_val    = ~x;
    y_val    = ~y;
    z_val    = ~z;
    mode     = ~m;
    checkOutput("busy_after_start", 32'(busy_w[k]), 32'd1);
  endtask

  task automatic wait_done(input int k, input string name, input logic [RW-1:0] exp_res,
                           input int exp_lat);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_w[k]) seen = 1'b1;
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, "_latency"}, 32'(cyc), 32'(exp_lat));
      checkOutput({name, "_result"}, 32'(res_w[k]), 32'(exp_res));
      checkOutput({name, "_busy_in_done"}, 32'(busy_w[k]), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy_w[0]), 32'd0);
    checkOutput("reset_done", 32'(done_w[0]), 32'd0);
    checkOutput("reset_result", 32'(res_w[0]), 32'd0);
    rst_n = 1'b1;

    applyStimulus(0, 1'b0, 8'd5, 8'd71, 8'd255);
    wait_done(0, "add_5x71", 17'h00262, 5);
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", 32'(done_w[0]), 32'd0);

    applyStimulus(0, 1'b1, 8'd5, 8'd71, 8'd255);
    wait_done(0, "sub_5x71", 17'd100, 5);
    applyStimulus(0, 1'b1, 8'd3, 8'd4, 8'd100);
    wait_done(0, "sub_neg", 17'h1FFA8, 3);

    applyStimulus(0, 1'b0, 8'd255, 8'd255, 8'd255);
    wait_done(0, "max_ops", 17'h0FF00, 5);
    applyStimulus(1, 1'b0, 8'd5, 8'd1, 8'd10);
    wait_done(1, "fixed_lat", 17'd15, 5);
    applyStimulus(0, 1'b0, 8'd5, 8'd1, 8'd10);
    wait_done(0, "early_lat", 17'd15, 2);

    applyStimulus(0, 1'b0, 8'd200, 8'd0, 8'd17);
    wait_done(0, "y_zero", 17'd17, 2);
    applyStimulus(1, 1'b0, 8'd200, 8'd0, 8'd17);
    wait_done(1, "y_zero_fixed", 17'd17, 5);

    // A start pulse while busy must be ignored; counting resumes from that ignored edge.
    applyStimulus(0, 1'b0, 8'd5, 8'd71, 8'd255);
    @(posedge clk);
    @(negedge clk);
    mode     = 1'b1;
    x_val    = 8'd9;
    y_val    = 8'd9;
    z_val    = 8'd9;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, "ignore_busy_start", 17'h00262, 3);
    applyStimulus(0, 1'b1, 8'd3, 8'd4, 8'd100);
    wait_done(0, "back_to_back", 17'h1FFA8, 3);

    applyStimulus(0, 1'b0, 8'd255, 8'd255, 8'd255);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", 32'(busy_w[0]), 32'd0);
    checkOutput("async_rst_done", 32'(done_w[0]), 32'd0);
    checkOutput("async_rst_result", 32'(res_w[0]), 32'd0);
    checkOutput("async_rst_result_fx", 32'(res_w[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      checkOutput("no_done_after_reset", 32'(done_w[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 8'd200, 8'd3, 8'd7);
    wait_done(0, "after_reset", 17'd607, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
